decode_stretch: RTL and testbench

DECODE_STRETCH -- requirements
Module: decode_stretch

---
 rtl/decode_stretch_pkg.sv | 35 +++
 rtl/code_fifo.sv | 71 +++++++
 rtl/decode_stretch.sv | 128 ++++++++++++
 tb/tb_decode_stretch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stretch_pkg.sv
// ----------------------------------------------------------------------------
// decode_stretch_pkg
// Shared definitions for the decode_stretch block and its code FIFO:
//   - state_e       : controller states (IDLE, DRIVE, GAP)
//   - CODE_W/OUT_W  : width of the binary code and of the one-hot output
//   - ENTRY_W       : width of one queued entry, {none, code}
//   - DEFAULT_HOLD / DEFAULT_DEPTH : default parameter values
//   - decodeEntry() : turns a queued entry into its one-hot output pattern
// ----------------------------------------------------------------------------
package decode_stretch_pkg;

   localparam int CODE_W        = 3;
   localparam int OUT_W         = 8;
   localparam int ENTRY_W       = CODE_W + 1;
   localparam int DEFAULT_HOLD  = 4;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_e;

   // A "none" entry (top bit set) decodes to all zeros; otherwise exactly
   // one bit is set, so the output can never carry more than one hot line.
   function automatic logic [OUT_W-1:0] decodeEntry(input logic [ENTRY_W-1:0] entry);
      logic [OUT_W-1:0] oneHot;
      oneHot = '0;
      if (!entry[CODE_W]) begin
         oneHot[entry[CODE_W-1:0]] = 1'b1;
      end
      return oneHot;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// ----------------------------------------------------------------------------
// code_fifo
// Small synchronous FIFO holding {none, code} entries for decode_stretch.
// Pointers carry one extra wrap bit so full and empty are told apart
// without an occupancy counter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers)
//   push_i       : write data_i this edge (ignored while full)
//   data_i       : entry to write
//   pop_i        : discard the head entry this edge (ignored while empty)
//   data_o       : current head entry
//   full_o       : no free slot
//   empty_o      : no stored entry
// ----------------------------------------------------------------------------
module code_fifo
   import decode_stretch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q;
   logic [AW:0]      rdPtr_q;
   logic             doPush;
   logic             doPop;

   assign doPush = push_i && !full_o;
   assign doPop  = pop_i && !empty_o;

   // Pointer registers: the low AW bits address storage and wrap naturally
   // modulo DEPTH, the top bit flips on every wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + (AW+1)'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + (AW+1)'(1);
         end
      end
   end

   // Storage needs no reset; a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= data_i;
      end
   end

   // Same address with different wrap bits means the writer lapped the reader.
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/decode_stretch.sv
// ----------------------------------------------------------------------------
// decode_stretch
// Queues binary codes (the encoder's D output plus a "none" flag) and
// replays each as a one-hot line held for HOLD cycles, followed by a
// one-cycle gap during which done pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : a code is offered on in_code / in_none
//   in_code    : binary index of the line to assert
//   in_none    : no line active; the entry drives Y=0 for its period
//   in_ready   : a code can be accepted this cycle
//   Y          : registered one-hot output
//   y_valid    : a decode period is in progress
//   done       : one-cycle pulse in the gap after each decode period
// ----------------------------------------------------------------------------
module decode_stretch
   import decode_stretch_pkg::*;
#(
   parameter int HOLD  = DEFAULT_HOLD,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_none,
   output logic              in_ready,
   output logic [OUT_W-1:0]  Y,
   output logic              y_valid,
   output logic              done
);

   localparam int CNT_W = $clog2(HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
   logic [OUT_W-1:0]   y_q,       y_d;
   logic               readyEn_q;
   logic               push;
   logic               pop;
   logic               fifoFull;
   logic               fifoEmpty;
   logic [ENTRY_W-1:0] fifoHead;

   // readyEn_q keeps in_ready low throughout reset and lets it rise on the
   // first edge after release. Full comes from registered pointers, so a pop
   // on the same edge never opens a slot for a push while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readyEn_q <= 1'b0;
      end else begin
         readyEn_q <= 1'b1;
      end
   end

   assign in_ready = readyEn_q && !fifoFull;
   assign push     = in_valid && in_ready;

   code_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({in_none, in_code}),
      .pop_i   (pop),
      .data_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // State, hold counter and output register. Reset clears them at once, so
   // an in-flight period is abandoned and done cannot pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         holdCnt_q <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
         y_q       <= y_d;
      end
   end

   // IDLE and GAP both start a new period when something is queued, which is
   // what gives back-to-back entries a period of HOLD+1 cycles. DRIVE counts
   // HOLD-1 down to 0, so it lasts exactly HOLD cycles.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = holdCnt_q;
      y_d       = y_q;
      pop       = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               state_d   = DRIVE;
               holdCnt_d = CNT_LOAD;
               y_d       = decodeEntry(fifoHead);
            end else begin
               state_d = IDLE;
               y_d     = '0;
            end
         end
         DRIVE: begin
            if (holdCnt_q == '0) begin
               state_d = GAP;
               y_d     = '0;
            end else begin
               holdCnt_d = holdCnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            holdCnt_d = '0;
            y_d       = '0;
         end
      endcase
   end

   assign Y       = y_q;
   assign y_valid = (state_q == DRIVE);
   assign done    = (state_q == GAP);

endmodule

// File: tb/tb_decode_stretch.sv
// ----------------------------------------------------------------------------
// tb_decode_stretch
// Drives two decode_stretch instances (HOLD=4 and HOLD=1) from the same
// inputs and compares every output, every cycle, against a queue-based
// reference model of each instance.
// ----------------------------------------------------------------------------
module tb_decode_stretch;

   localparam int DEPTH = 4;
   localparam int NDUT  = 2;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic [2:0] inCode;
   logic       inNone;

   logic       ready4, yValid4, done4;
   logic [7:0] y4;
   logic       ready1, yValid1, done1;
   logic [7:0] y1;

   int checkCount;
   int failCount;

   // Reference model: a queue of accepted entries per instance, plus the
   // number of cycles left in the current period (HOLD drive cycles followed
   // by one gap cycle). Zero means idle.
   logic [3:0] q0[$];
   logic [3:0] q1[$];
   int         slotsLeft [NDUT];
   logic [3:0] curEntry  [NDUT];
   bit         started   [NDUT];
   bit         lastAcc   [NDUT];
   int         holdOf    [NDUT];

   decode_stretch #(.HOLD(4), .DEPTH(DEPTH)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (inValid),
      .in_code  (inCode),
      .in_none  (inNone),
      .in_ready (ready4),
      .Y        (y4),
      .y_valid  (yValid4),
      .done     (done4)
   );

   decode_stretch #(.HOLD(1), .DEPTH(DEPTH)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (inValid),
      .in_code  (inCode),
      .in_none  (inNone),
      .in_ready (ready1),
      .Y        (y1),
      .y_valid  (yValid1),
      .done     (done1)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int qSize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic modelReset();
      q0.delete();
      q1.delete();
      for (int i = 0; i < NDUT; i++) begin
         slotsLeft[i] = 0;
         curEntry[i]  = '0;
         started[i]   = 1'b0;
         lastAcc[i]   = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compare all outputs of both instances with what the model predicts.
   task automatic checkAll();
      logic [7:0] expY;
      logic       expValid;
      logic       expDone;
      logic       expReady;
      for (int i = 0; i < NDUT; i++) begin
         expValid = (slotsLeft[i] > 1);
         expDone  = (slotsLeft[i] == 1);
         expReady = started[i] && (qSize(i) < DEPTH);
         expY     = 8'd0;
         if (expValid && !curEntry[i][3]) begin
            expY = 8'(1 << curEntry[i][2:0]);
         end
         checkOutput($sformatf("Y_hold%0d", holdOf[i]), (i == 0) ? y4 : y1, expY);
         checkOutput($sformatf("y_valid_hold%0d", holdOf[i]),
                     {7'd0, (i == 0) ? yValid4 : yValid1}, {7'd0, expValid});
         checkOutput($sformatf("done_hold%0d", holdOf[i]),
                     {7'd0, (i == 0) ? done4 : done1}, {7'd0, expDone});
         checkOutput($sformatf("in_ready_hold%0d", holdOf[i]),
                     {7'd0, (i == 0) ? ready4 : ready1}, {7'd0, expReady});
      end
   endtask

   task automatic applyStimulus(input logic v, input logic none, input logic [2:0] code);
      inValid = v;
      inNone  = none;
      inCode  = code;
   endtask

   // One clock cycle: decide acceptance from the model's pre-edge state,
   // advance the model across the edge, then sample the DUTs 1 unit later.
   task automatic tick();
      bit acc [NDUT];
      for (int i = 0; i < NDUT; i++) begin
         acc[i] = rst_n && inValid && started[i] && (qSize(i) < DEPTH);
      end
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            if (slotsLeft[i] <= 1 && qSize(i) > 0) begin
               curEntry[i]  = (i == 0) ? q0.pop_front() : q1.pop_front();
               slotsLeft[i] = holdOf[i] + 1;
            end else if (slotsLeft[i] > 0) begin
               slotsLeft[i]--;
            end
            if (acc[i]) begin
               if (i == 0) q0.push_back({inNone, inCode});
               else        q1.push_back({inNone, inCode});
            end
            lastAcc[i] = acc[i];
            started[i] = 1'b1;
         end
      end
      #1;
      checkAll();
   endtask

   // Assert reset between edges and check outputs clear without a clock.
   task automatic asyncReset();
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkAll();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkAll();
   endtask

   initial begin
      int guard;
      checkCount = 0;
      failCount  = 0;
      holdOf[0]  = 4;
      holdOf[1]  = 1;
      applyStimulus(1'b0, 1'b0, 3'd0);
      rst_n = 1'b0;
      modelReset();

      // Power-on reset: outputs must be clear with no clock edge at all.
      #1;
      checkAll();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkAll();
      tick();

      // Single code 5 into an empty FIFO.
      $display("[TB] single code 5");
      applyStimulus(1'b1, 1'b0, 3'd5);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (8) tick();

      // Codes 0..7 back to back, each offered until the HOLD=4 instance takes it.
      $display("[TB] codes 0..7 back to back");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 1'b0, 3'(c));
         guard = 0;
         do begin
            tick();
            guard++;
         end while (!lastAcc[0] && guard < 50);
      end
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (45) tick();

      // A none entry: a full-length period with Y held at zero.
      $display("[TB] none entry");
      applyStimulus(1'b1, 1'b1, 3'($urandom_range(0, 7)));
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (8) tick();

      // in_valid held high with changing codes: FIFO stays full, pointers wrap.
      $display("[TB] saturating stream");
      for (int n = 0; n < 80; n++) begin
         applyStimulus(1'b1, 1'(($urandom_range(0, 7) == 0)), 3'($urandom_range(0, 7)));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (45) tick();

      // Reset mid-DRIVE with entries still queued.
      $display("[TB] reset mid-drive");
      for (int c = 2; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, 3'(c));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 3'd0);
      tick();
      asyncReset();
      repeat (10) tick();

      // Codes 3 then 6 streamed; the HOLD=1 instance drives each for one cycle.
      $display("[TB] stream 3,6");
      applyStimulus(1'b1, 1'b0, 3'd3);
      tick();
      applyStimulus(1'b1, 1'b0, 3'd6);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (14) tick();

      // Random traffic, with one more asynchronous reset dropped in.
      $display("[TB] random traffic");
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'(($urandom_range(0, 5) == 0)),
                       3'($urandom_range(0, 7)));
         if (n == 150) begin
            asyncReset();
         end
         tick();
      end
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (45) tick();

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
